xor_acc_ctrl: RTL and testbench

XOR_ACC_CTRL -- requirements
Module: xor_acc_ctrl

---
 rtl/xor_acc_pkg.sv | 11 +
 rtl/xor_acc_ctrl.sv | 103 ++++++++++
 tb/tb_xor_acc_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/xor_acc_pkg.sv
// Shared FSM encoding and beat-counter sizing for the XOR accumulate controller.
package xor_acc_pkg;

  localparam logic [1:0] ST_ACC      = 2'd0;
  localparam logic [1:0] ST_CLR_WAIT = 2'd1;
  localparam logic [1:0] ST_CLR      = 2'd2;

  localparam int BEAT_CNT_W = 16;
  localparam logic [BEAT_CNT_W-1:0] BEAT_CNT_MAX = '1;

endpackage

// File: rtl/xor_acc_ctrl.sv
// XOR-accumulate controller for a dual-port RAM plus a whole-memory clear sequencer.
// Beats write back one cycle after acceptance; in_ready is low only while a clear is pending or running.
module xor_acc_ctrl
  import xor_acc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  clear_start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [AW-1:0]         in_addr,
  input  logic [WIDTH-1:0]      in_data,
  output logic [AW-1:0]         mem_address_0,
  input  logic [WIDTH-1:0]      mem_q_0,
  output logic [AW-1:0]         mem_address_1,
  output logic [WIDTH-1:0]      mem_data_1,
  output logic                  mem_wren_1,
  output logic                  mem_wren_0,
  output logic                  busy,
  output logic                  clear_done,
  output logic [BEAT_CNT_W-1:0] beat_count
);

  logic [1:0]       state;
  logic             s1_vld;
  logic             s1_fwd;
  logic [AW-1:0]    s1_addr;
  logic [WIDTH-1:0] s1_data;
  logic [WIDTH-1:0] s1_res;
  logic [WIDTH-1:0] last_res;
  logic [AW-1:0]    clr_addr;
  logic             done_q;
  logic             accept;

  assign in_ready      = ~rst & (state == ST_ACC);
  assign accept        = in_valid & in_ready;
  assign mem_address_0 = in_addr;
  assign mem_wren_0    = 1'b0;
  assign busy          = ~rst & ((state != ST_ACC) | s1_vld);
  assign clear_done    = ~rst & done_q;

  // The RAM returns old data when read and written at the same address in one cycle,
  // so a same-address follower takes the previous stage-1 result instead of mem_q_0.
  assign s1_res = s1_data ^ (s1_fwd ? last_res : mem_q_0);

  always_comb begin
    mem_wren_1    = 1'b0;
    mem_address_1 = s1_addr;
    mem_data_1    = s1_res;
    if (!rst) begin
      if (state == ST_CLR) begin
        mem_wren_1    = 1'b1;
        mem_address_1 = clr_addr;
        mem_data_1    = '0;
      end else if (s1_vld) begin
        mem_wren_1 = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state      <= ST_ACC;
      s1_vld     <= 1'b0;
      s1_fwd     <= 1'b0;
      clr_addr   <= '0;
      beat_count <= '0;
      done_q     <= 1'b0;
    end else begin
      s1_vld <= accept;
      s1_fwd <= accept & s1_vld & (in_addr == s1_addr);
      if (accept) begin
        s1_addr <= in_addr;
        s1_data <= in_data;
      end
      if (s1_vld) last_res <= s1_res;
      if (accept && beat_count != BEAT_CNT_MAX) beat_count <= beat_count + 1'b1;
      done_q <= 1'b0;

      case (state)
        ST_ACC:      if (clear_start) state <= ST_CLR_WAIT;
        ST_CLR_WAIT: if (!s1_vld) state <= ST_CLR;
        ST_CLR: begin
          // Terminate on the last index rather than wrap so non-power-of-2 depths work.
          if (clr_addr == AW'(DEPTH - 1)) begin
            state      <= ST_ACC;
            clr_addr   <= '0;
            done_q     <= 1'b1;
            beat_count <= '0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        default:     state <= ST_ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_acc_ctrl.sv
// Bench for xor_acc_ctrl: behavioural RAM with zero init, a per-cycle reference model
// of accepted beats and clear sequencing, directed scenarios and a randomized phase.
module tb_xor_acc_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic             clock = 1'b0;
  logic             rst = 1'b1;
  logic             clear_start = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [AW-1:0]    in_addr = '0;
  logic [WIDTH-1:0] in_data = '0;
  logic [AW-1:0]    mem_address_0;
  logic [WIDTH-1:0] mem_q_0;
  logic [AW-1:0]    mem_address_1;
  logic [WIDTH-1:0] mem_data_1;
  logic             mem_wren_1;
  logic             mem_wren_0;
  logic             busy;
  logic             clear_done;
  logic [15:0]      beat_count;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  always #5 clock = ~clock;

  xor_acc_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock         (clock),
    .rst           (rst),
    .clear_start   (clear_start),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_addr       (in_addr),
    .in_data       (in_data),
    .mem_address_0 (mem_address_0),
    .mem_q_0       (mem_q_0),
    .mem_address_1 (mem_address_1),
    .mem_data_1    (mem_data_1),
    .mem_wren_1    (mem_wren_1),
    .mem_wren_0    (mem_wren_0),
    .busy          (busy),
    .clear_done    (clear_done),
    .beat_count    (beat_count)
  );

  // Dual-port RAM, zero-initialised, registered read returning old data on a same-cycle write.
  logic [WIDTH-1:0] mem [DEPTH] = '{default: '0};
  always @(posedge clock) begin
    mem_q_0 <= mem[mem_address_0];
    if (mem_wren_1) mem[mem_address_1] <= mem_data_1;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Reference model: memory image, pending write from last cycle's beat, clear window.
  logic [WIDTH-1:0] ref_mem [DEPTH] = '{default: '0};
  logic             pend_vld = 1'b0;
  logic [AW-1:0]    pend_addr = '0;
  logic [WIDTH-1:0] pend_data = '0;
  logic             in_clear = 1'b0;
  logic             done_exp = 1'b0;
  int               clr_first = 0;
  int               exp_cnt = 0;
  logic             e_rdy, e_wr, e_busy, acc;
  logic [AW-1:0]    e_wa;
  logic [WIDTH-1:0] e_wd;

  initial forever begin
    @(negedge clock);
    if (rst) begin
      chk("rst_in_ready",   64'(in_ready),   64'd0);
      chk("rst_busy",       64'(busy),       64'd0);
      chk("rst_clear_done", 64'(clear_done), 64'd0);
      chk("rst_wren_1",     64'(mem_wren_1), 64'd0);
      chk("rst_wren_0",     64'(mem_wren_0), 64'd0);
      pend_vld = 1'b0;
      in_clear = 1'b0;
      done_exp = 1'b0;
      exp_cnt  = 0;
    end else begin
      e_rdy = !in_clear;
      e_wr  = pend_vld;
      e_wa  = pend_addr;
      e_wd  = pend_data;
      if (in_clear && cyc >= clr_first) begin
        e_wr = 1'b1;
        e_wa = AW'(cyc - clr_first);
        e_wd = '0;
      end
      e_busy = in_clear | pend_vld;
      chk("in_ready",   64'(in_ready),   64'(e_rdy));
      chk("busy",       64'(busy),       64'(e_busy));
      chk("clear_done", 64'(clear_done), 64'(done_exp));
      chk("wren_0",     64'(mem_wren_0), 64'd0);
      chk("wren_1",     64'(mem_wren_1), 64'(e_wr));
      chk("beat_count", 64'(beat_count), 64'(exp_cnt));
      if (e_wr) begin
        chk("wr_addr", 64'(mem_address_1), 64'(e_wa));
        chk("wr_data", 64'(mem_data_1),    64'(e_wd));
      end
      if (e_rdy) chk("rd_addr", 64'(mem_address_0), 64'(in_addr));

      acc      = in_valid & e_rdy;
      pend_vld = acc;
      if (acc) begin
        ref_mem[in_addr] = ref_mem[in_addr] ^ in_data;
        pend_addr = in_addr;
        pend_data = ref_mem[in_addr];
        if (exp_cnt < 65535) exp_cnt++;
      end
      done_exp = 1'b0;
      if (in_clear && cyc == clr_first + DEPTH - 1) begin
        in_clear = 1'b0;
        done_exp = 1'b1;
        exp_cnt  = 0;
      end else if (!in_clear && clear_start) begin
        // One drain cycle, plus one more if a beat was accepted alongside the request.
        in_clear  = 1'b1;
        clr_first = cyc + 2 + (acc ? 1 : 0);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic beat(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    int nd;
    int bad;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clock);
    chk("post_rst_ready", 64'(in_ready),   64'd1);
    chk("post_rst_count", 64'(beat_count), 64'd0);
    step();

    beat(6'd5, 8'h3C);
    @(negedge clock);
    chk("single_wren", 64'(mem_wren_1),    64'd1);
    chk("single_addr", 64'(mem_address_1), 64'd5);
    chk("single_data", 64'(mem_data_1),    64'h3C);
    step();

    beat(6'd7, 8'h0F);
    beat(6'd7, 8'hF0);
    @(negedge clock);
    chk("b2b_addr", 64'(mem_address_1), 64'd7);
    chk("b2b_data", 64'(mem_data_1),    64'hFF);
    step();
    step();
    chk("b2b_mem7", 64'(mem[7]), 64'hFF);

    // Clear requested in the same cycle as a beat.
    in_valid    = 1'b1;
    in_addr     = 6'd9;
    in_data     = 8'h55;
    clear_start = 1'b1;
    step();
    in_valid    = 1'b0;
    clear_start = 1'b0;
    @(negedge clock);
    chk("inflight_wren", 64'(mem_wren_1),    64'd1);
    chk("inflight_addr", 64'(mem_address_1), 64'd9);
    chk("inflight_data", 64'(mem_data_1),    64'h55);
    nd = 0;
    repeat (100) begin
      @(negedge clock);
      if (clear_done) nd++;
    end
    chk("clear_done_pulses", 64'(nd), 64'd1);
    chk("clear_count",       64'(beat_count), 64'd0);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] != '0) bad++;
    chk("clear_nonzero_words", 64'(bad), 64'd0);
    step();

    beat(6'd1, 8'h01);
    beat(6'd2, 8'h02);
    beat(6'd1, 8'h04);
    step();
    step();
    @(negedge clock);
    chk("ilv_mem1",  64'(mem[1]),     64'h05);
    chk("ilv_mem2",  64'(mem[2]),     64'h02);
    chk("ilv_count", 64'(beat_count), 64'd3);
    step();

    // Random traffic concentrated on a few addresses to stress forwarding.
    for (int i = 0; i < 2000; i++) begin
      in_valid    = 1'($urandom_range(0, 1));
      in_addr     = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, DEPTH - 1));
      in_data     = WIDTH'($urandom);
      clear_start = ($urandom_range(0, 249) == 0);
      step();
    end
    in_valid    = 1'b0;
    clear_start = 1'b0;
    for (int i = 0; i < 200 && busy; i++) @(negedge clock);
    chk("drain_idle", 64'(busy), 64'd0);
    step();

    // Reset in the middle of a clear.
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    for (int i = 0; i < 100 && !(mem_wren_1 && mem_address_1 == 6'd20); i++) @(negedge clock);
    chk("clr_reach_20", 64'(mem_address_1), 64'd20);
    @(posedge clock);
    #1 rst = 1'b1;
    @(negedge clock);
    chk("midclr_rst_ready", 64'(in_ready), 64'd0);
    step();
    step();
    rst = 1'b0;
    @(negedge clock);
    chk("midclr_post_ready", 64'(in_ready), 64'd1);
    nd = 0;
    repeat (80) begin
      @(negedge clock);
      if (clear_done) nd++;
    end
    chk("midclr_no_done", 64'(nd), 64'd0);
    step();
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    nd = 0;
    repeat (100) begin
      @(negedge clock);
      if (clear_done) nd++;
    end
    chk("reclear_done", 64'(nd), 64'd1);
    step();

    for (int i = 0; i < 65540; i++) begin
      in_valid = 1'b1;
      in_addr  = AW'($urandom_range(0, DEPTH - 1));
      in_data  = WIDTH'($urandom);
      step();
    end
    in_valid = 1'b0;
    @(negedge clock);
    chk("sat_count", 64'(beat_count), 64'hFFFF);
    step();
    step();

    bad = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] != ref_mem[i]) bad++;
    chk("final_mem_words", 64'(bad), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
